// File: rtl/mem_responder.sv
// Word-addressed memory target for the core's RAM port: req/ack handshake with
// configurable wait states, byte-enable writes and out-of-range error reporting.
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;

    logic        we_p0;
    logic [29:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;

    logic [31:0] mem [DEPTH];

    logic              acc_fire;
    logic              acc_we;
    logic [29:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_in_range;
    logic [ADDR_W-1:0] acc_idx;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // The access happens on the edge entering RESP; with no wait states that is
    // the capture edge itself, so the live inputs are used instead of the copies.
    always_comb begin
        acc_fire  = 1'b0;
        acc_we    = we_p0;
        acc_addr  = addr_p0;
        acc_wdata = wdata_p0;
        acc_be    = be_p0;
        if (state == ST_IDLE) begin
            acc_fire  = req && (WAIT_CYCLES == 0);
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end else if (state == ST_WAIT) begin
            acc_fire = (cnt == 4'd0);
        end
    end

    assign acc_in_range = (acc_addr >> ADDR_W) == 30'd0;
    assign acc_idx      = acc_addr[ADDR_W-1:0];

    // Commit is gated by reset so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (reset_n && acc_fire && acc_we && acc_in_range) begin
            mem[acc_idx] <= merge_lanes(mem[acc_idx], acc_wdata, acc_be);
        end
    end

    // ---- stage p0: request capture, wait countdown, response ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            rdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        we_p0    <= we;
                        addr_p0  <= addr;
                        wdata_p0 <= wdata;
                        be_p0    <= be;
                        cnt      <= CNT_INIT;
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (acc_fire) begin
                state <= ST_RESP;
                ack   <= 1'b1;
                busy  <= 1'b1;
                if (!acc_in_range) begin
                    err   <= 1'b1;
                    rdata <= 32'h0;
                end else if (!acc_we) begin
                    rdata <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WC_A   = 2;
    localparam int WC_B   = 0;

    logic        clk;
    logic        reset_n;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [29:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  be_s    [2];
    logic [31:0] rdata_s [2];
    logic        ack_s   [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    int checks   = 0;
    int failures = 0;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .be(be_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]),
        .err(err_s[0]), .busy(busy_s[0]));

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .be(be_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]),
        .err(err_s[1]), .busy(busy_s[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? WC_A : WC_B;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a transaction is captured from idle, its memory effect and
    // response appear WAIT_CYCLES edges later, and the ack lasts one cycle.
    logic [31:0] mmem [int];
    bit          started = 0;
    int          edge_n  = 0;
    bit          pend    [2];
    bit          in_resp [2];
    int          resp_edge [2];
    logic        c_we    [2];
    logic [29:0] c_addr  [2];
    logic [31:0] c_wdata [2];
    logic [3:0]  c_be    [2];
    logic        exp_ack [2];
    logic        exp_err [2];
    logic        exp_busy[2];
    logic [31:0] exp_rdata [2];
    bit          rd_known [2];

    task automatic model_access(input int i);
        int          key;
        logic [31:0] mask;
        logic [31:0] w;
        key = i * DEPTH + int'(c_addr[i] % DEPTH);
        if (c_addr[i] >= 30'(DEPTH)) begin
            exp_err[i]   = 1'b1;
            exp_rdata[i] = 32'h0;
            rd_known[i]  = 1'b1;
        end else if (c_we[i]) begin
            exp_err[i] = 1'b0;
            mask = {{8{c_be[i][3]}}, {8{c_be[i][2]}}, {8{c_be[i][1]}}, {8{c_be[i][0]}}};
            if (c_be[i] == 4'hF) begin
                mmem[key] = c_wdata[i];
            end else if (mmem.exists(key)) begin
                w = mmem[key];
                mmem[key] = (w & ~mask) | (c_wdata[i] & mask);
            end
        end else begin
            exp_err[i] = 1'b0;
            if (mmem.exists(key)) begin
                exp_rdata[i] = mmem[key];
                rd_known[i]  = 1'b1;
            end else begin
                rd_known[i] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                pend[i] = 0; in_resp[i] = 0;
                exp_ack[i] = 0; exp_err[i] = 0; exp_busy[i] = 0;
                exp_rdata[i] = 32'h0; rd_known[i] = 1;
                started = 1;
            end else if (in_resp[i]) begin
                in_resp[i] = 0;
                exp_ack[i] = 0; exp_err[i] = 0; exp_busy[i] = 0;
            end else begin
                if (!pend[i] && req_s[i]) begin
                    c_we[i] = we_s[i]; c_addr[i] = addr_s[i];
                    c_wdata[i] = wdata_s[i]; c_be[i] = be_s[i];
                    pend[i] = 1;
                    resp_edge[i] = edge_n + wc(i);
                    exp_busy[i] = 1;
                end
                if (pend[i] && edge_n == resp_edge[i]) begin
                    model_access(i);
                    pend[i] = 0;
                    in_resp[i] = 1;
                    exp_ack[i] = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d ack", i), 32'(ack_s[i]), 32'(exp_ack[i]));
                check($sformatf("u%0d err", i), 32'(err_s[i]), 32'(exp_err[i]));
                check($sformatf("u%0d busy", i), 32'(busy_s[i]), 32'(exp_busy[i]));
                if (rd_known[i]) check($sformatf("u%0d rdata", i), rdata_s[i], exp_rdata[i]);
            end
        end
    end

    task automatic access(input int i, input logic w, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d; be_s[i] = b;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_s[i] = 1'b0;
            if (ack_s[i]) begin
                lat = k; rd = rdata_s[i]; er = err_s[i];
                break;
            end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL u%0d ack_timeout: got no ack expected ack within 40 cycles", i);
        end
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 40; k++) begin
            if (!busy_s[i]) break;
            @(negedge clk);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b1; we_s[i] = 1'b0; addr_s[i] = 30'h0;
            wdata_s[i] = 32'h0; be_s[i] = 4'hF;
        end

        // Reset held with req high
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("rst ack", 32'(ack_s[i]), 32'd0);
                check("rst busy", 32'(busy_s[i]), 32'd0);
                check("rst err", 32'(err_s[i]), 32'd0);
                check("rst rdata", rdata_s[i], 32'h0);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("first capture busy u0", 32'(busy_s[0]), 32'd1);
        check("first capture busy u1", 32'(busy_s[1]), 32'd1);
        req_s[0] = 1'b0; req_s[1] = 1'b0;
        wait_idle(0); wait_idle(1);

        // Write then read, 2 wait states
        access(0, 1'b1, 30'h005, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("wr latency", 32'(lat), 32'd3);
        check("wr err", 32'(er), 32'd0);
        access(0, 1'b0, 30'h005, 32'h0, 4'hF, rd, er, lat);
        check("rd data", rd, 32'hDEADBEEF);
        check("rd err", 32'(er), 32'd0);

        // Byte enables, including an all-lanes-off write
        access(0, 1'b1, 30'h010, 32'h11223344, 4'hF, rd, er, lat);
        access(0, 1'b1, 30'h010, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        access(0, 1'b0, 30'h010, 32'h0, 4'hF, rd, er, lat);
        check("be merge", rd, 32'h11BB33DD);
        access(0, 1'b1, 30'h010, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        check("be0 ack", 32'(lat), 32'd3);
        access(0, 1'b0, 30'h010, 32'h0, 4'hF, rd, er, lat);
        check("be0 unchanged", rd, 32'h11BB33DD);

        // Out of range with aliasing index
        access(0, 1'b1, 30'h000, 32'h00000A5A, 4'hF, rd, er, lat);
        access(0, 1'b1, 30'h400, 32'h12345678, 4'hF, rd, er, lat);
        check("oor err", 32'(er), 32'd1);
        check("oor rdata", rd, 32'h0);
        access(0, 1'b0, 30'h000, 32'h0, 4'hF, rd, er, lat);
        check("alias rdata", rd, 32'h00000A5A);
        check("alias err", 32'(er), 32'd0);

        // Back-to-back reads, zero wait states
        access(1, 1'b1, 30'h001, 32'h01010101, 4'hF, rd, er, lat);
        check("wc0 latency", 32'(lat), 32'd1);
        access(1, 1'b1, 30'h002, 32'h02020202, 4'hF, rd, er, lat);
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 30'h001;
        @(negedge clk);
        check("b2b ack1", 32'(ack_s[1]), 32'd1);
        check("b2b data1", rdata_s[1], 32'h01010101);
        addr_s[1] = 30'h002;
        @(negedge clk);
        check("b2b gap", 32'(ack_s[1]), 32'd0);
        @(negedge clk);
        check("b2b ack2", 32'(ack_s[1]), 32'd1);
        check("b2b data2", rdata_s[1], 32'h02020202);
        req_s[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("b2b no third ack", 32'(ack_s[1]), 32'd0);
        end

        // Reset landing on the commit edge of a write
        access(0, 1'b1, 30'h020, 32'h0, 4'hF, rd, er, lat);
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 30'h020;
        wdata_s[0] = 32'hCAFEF00D; be_s[0] = 4'hF;
        @(negedge clk);
        req_s[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            check("abandon no ack", 32'(ack_s[0]), 32'd0);
            @(negedge clk);
        end
        access(0, 1'b0, 30'h020, 32'h0, 4'hF, rd, er, lat);
        check("abandon rdata", rd, 32'h0);

        // Random traffic, req free-running, occasional reset
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < 2; i++) begin
                int r;
                r = $urandom_range(0, 7);
                req_s[i]   = ($urandom_range(0, 2) != 0);
                we_s[i]    = $urandom_range(0, 1) == 1;
                wdata_s[i] = $urandom;
                be_s[i]    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                if (r == 0)      addr_s[i] = 30'h400 | 30'($urandom_range(0, 15));
                else if (r == 1) addr_s[i] = 30'($urandom);
                else             addr_s[i] = 30'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        req_s[0] = 1'b0; req_s[1] = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
